// File: rtl/mod_sched_pkg.sv
// mod_sched_pkg: shared types and constants for the interval scheduler
//   state_t  - scheduler FSM encoding (IDLE, RUN, PAUSE)
//   RPT_CONT - repeat count value that selects continuous mode
package mod_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int RPT_CONT = 0;

endpackage

// File: rtl/mod_counter_prog.sv
// mod_counter_prog: modulo counter that runs 0..terminal inclusive
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : advance the counter this cycle
//   clr          : synchronous clear, overrides en
//   terminal     : inclusive terminal value
//   q            : current count
//   wrap         : count is at terminal while enabled
module mod_counter_prog #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    assign wrap = en & (q == terminal);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= wrap ? '0 : q + 1'b1;
    end

endmodule

// File: rtl/mod_counter_sched.sv
// mod_counter_sched: programmable interval scheduler built on a modulo counter
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a run (sampled only in IDLE)
//   stop         : abort a run, highest priority
//   pause        : level, holds the count while high
//   period       : inclusive terminal value, latched at start
//   repeat_cnt   : periods to run, latched at start; 0 runs continuously
//   count        : current counter value
//   wrap         : counter at terminal while enabled
//   done         : one-cycle pulse after the final wrap
//   busy         : in RUN or PAUSE
//   paused       : in PAUSE
//   periods_left : remaining periods including the current one
module mod_counter_sched
    import mod_sched_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RPT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic [WIDTH-1:0]     period,
    input  logic [RPT_WIDTH-1:0] repeat_cnt,
    output logic [WIDTH-1:0]     count,
    output logic                 wrap,
    output logic                 done,
    output logic                 busy,
    output logic                 paused,
    output logic [RPT_WIDTH-1:0] periods_left
);

    state_t               state;
    logic [WIDTH-1:0]     period_l;
    logic [RPT_WIDTH-1:0] rpt_l;
    logic                 en;
    logic                 bounded;
    logic                 last;

    assign busy    = state != IDLE;
    assign paused  = state == PAUSE;
    assign en      = busy & ~pause & ~stop;
    assign bounded = rpt_l != RPT_WIDTH'(RPT_CONT);
    // wrap already implies en, so a stop can never produce the final wrap
    assign last    = wrap & bounded & (periods_left == RPT_WIDTH'(1));

    mod_counter_prog #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .clr      (stop),
        .terminal (period_l),
        .q        (count),
        .wrap     (wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            period_l     <= '0;
            rpt_l        <= '0;
            periods_left <= '0;
            done         <= 1'b0;
        end else begin
            done <= last;
            if (stop) begin
                state        <= IDLE;
                periods_left <= '0;
            end else if (state == IDLE) begin
                if (start) begin
                    state        <= RUN;
                    period_l     <= period;
                    rpt_l        <= repeat_cnt;
                    periods_left <= repeat_cnt;
                end
            end else begin
                if (wrap && bounded)
                    periods_left <= periods_left - 1'b1;
                // leaving PAUSE resumes counting in the same cycle, so RUN follows
                state <= last ? IDLE : (pause ? PAUSE : RUN);
            end
        end
    end

endmodule

// File: tb/tb_mod_counter_sched.sv
// tb_mod_counter_sched: directed vector bench for mod_counter_sched
module tb_mod_counter_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, stop, pause;
    logic [7:0] period;
    logic [3:0] repeat_cnt;
    logic [7:0] count;
    logic       wrap, done, busy, paused;
    logic [3:0] periods_left;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       st, sp, pa;
        logic [7:0] per;
        logic [3:0] rpt;
        logic [7:0] c;
        logic       w, d, b, p;
        logic [3:0] l;
    } vec_t;

    vec_t tv[$];

    mod_counter_sched #(.WIDTH(8), .RPT_WIDTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .period       (period),
        .repeat_cnt   (repeat_cnt),
        .count        (count),
        .wrap         (wrap),
        .done         (done),
        .busy         (busy),
        .paused       (paused),
        .periods_left (periods_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic add(input logic st, sp, pa, input logic [7:0] per, input logic [3:0] rpt,
                       input logic [7:0] c, input logic w, d, b, p, input logic [3:0] l);
        tv.push_back('{st, sp, pa, per, rpt, c, w, d, b, p, l});
    endtask

    task automatic chk_all(input string nm, input logic [7:0] c, input logic w, d, b, p,
                           input logic [3:0] l);
        chk({nm, ".count"}, count, c);
        chk({nm, ".wrap"}, wrap, w);
        chk({nm, ".done"}, done, d);
        chk({nm, ".busy"}, busy, b);
        chk({nm, ".paused"}, paused, p);
        chk({nm, ".left"}, periods_left, l);
    endtask

    task automatic drive(input logic st, sp, pa, input logic [7:0] per, input logic [3:0] rpt);
        @(negedge clk);
        start = st; stop = sp; pause = pa; period = per; repeat_cnt = rpt;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] m;
        int wraps;
        reset_n = 1'b0; start = 0; stop = 0; pause = 0; period = 0; repeat_cnt = 0;
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // period 3 x2, with a mid-run start/period change that must be ignored
        add(1,0,0,3,2, 0,0,0,0,0,0);
        add(0,0,0,3,2, 0,0,0,1,0,2);
        add(1,0,0,9,5, 1,0,0,1,0,2);
        add(0,0,0,9,5, 2,0,0,1,0,2);
        add(0,0,0,9,5, 3,1,0,1,0,2);
        add(0,0,0,9,5, 0,0,0,1,0,1);
        add(0,0,0,9,5, 1,0,0,1,0,1);
        add(0,0,0,9,5, 2,0,0,1,0,1);
        add(0,0,0,9,5, 3,1,0,1,0,1);
        // start in the done cycle: period 0 x3
        add(1,0,0,0,3, 0,0,1,0,0,0);
        add(0,0,0,0,3, 0,1,0,1,0,3);
        add(0,0,0,0,3, 0,1,0,1,0,2);
        add(0,0,0,0,3, 0,1,0,1,0,1);
        add(0,0,0,0,3, 0,0,1,0,0,0);
        // start together with stop stays idle
        add(1,1,0,2,1, 0,0,0,0,0,0);
        add(0,0,0,2,1, 0,0,0,0,0,0);
        // period 7 x1, stop at count 4
        add(1,0,0,7,1, 0,0,0,0,0,0);
        add(0,0,0,7,1, 0,0,0,1,0,1);
        add(0,0,0,7,1, 1,0,0,1,0,1);
        add(0,0,0,7,1, 2,0,0,1,0,1);
        add(0,0,0,7,1, 3,0,0,1,0,1);
        add(0,1,0,7,1, 4,0,0,1,0,1);
        add(0,0,0,7,1, 0,0,0,0,0,0);
        // fresh run after stop, with a short pause, then stop
        add(1,0,0,7,1, 0,0,0,0,0,0);
        add(0,0,0,7,1, 0,0,0,1,0,1);
        add(0,0,0,7,1, 1,0,0,1,0,1);
        add(0,0,1,7,1, 2,0,0,1,0,1);
        add(0,0,1,7,1, 2,0,0,1,1,1);
        add(0,0,0,7,1, 2,0,0,1,1,1);
        add(0,0,0,7,1, 3,0,0,1,0,1);
        add(0,1,0,7,1, 4,0,0,1,0,1);
        add(0,0,0,7,1, 0,0,0,0,0,0);
        // stop suppresses a wrap on period 0
        add(1,0,0,0,2, 0,0,0,0,0,0);
        add(0,1,0,0,2, 0,0,0,1,0,2);
        add(0,0,0,0,2, 0,0,0,0,0,0);
        // stop while paused
        add(1,0,0,4,1, 0,0,0,0,0,0);
        add(0,0,1,4,1, 0,0,0,1,0,1);
        add(0,0,1,4,1, 0,0,0,1,1,1);
        add(0,1,1,4,1, 0,0,0,1,1,1);
        add(0,0,0,4,1, 0,0,0,0,0,0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].st, tv[i].sp, tv[i].pa, tv[i].per, tv[i].rpt);
            chk_all($sformatf("v%0d", i), tv[i].c, tv[i].w, tv[i].d, tv[i].b, tv[i].p, tv[i].l);
        end

        // continuous mode, pause for 4 cycles at count 2, then 50 free cycles
        drive(1,0,0,5,0);
        drive(0,0,0,5,0); chk("cont.c0", count, 0);
        drive(0,0,0,5,0); chk("cont.c1", count, 1);
        drive(0,0,1,5,0); chk("cont.c2", count, 2); chk("cont.p2", paused, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0,0,1,5,0);
            chk($sformatf("cont.hold%0d", i), count, 2);
            chk($sformatf("cont.paused%0d", i), paused, 1);
            chk($sformatf("cont.wrap%0d", i), wrap, 0);
        end
        drive(0,0,0,5,0); chk("cont.resume", count, 2); chk("cont.resp", paused, 1);
        m = 8'd3;
        wraps = 0;
        for (int i = 0; i < 50; i++) begin
            drive(0,0,0,5,0);
            chk($sformatf("cont.c%0d", i), count, m);
            chk($sformatf("cont.w%0d", i), wrap, m == 8'd5);
            chk($sformatf("cont.d%0d", i), done, 0);
            chk($sformatf("cont.b%0d", i), busy, 1);
            chk($sformatf("cont.l%0d", i), periods_left, 0);
            wraps += (wrap === 1'b1) ? 1 : 0;
            m = (m == 8'd5) ? 8'd0 : m + 8'd1;
        end
        chk("cont.wraps", wraps, 8);
        drive(0,1,0,5,0);
        drive(0,0,0,5,0); chk_all("cont.stopped", 0, 0, 0, 0, 0, 0);

        // full-range period 255, one repeat
        drive(1,0,0,255,1);
        for (int i = 0; i < 256; i++) begin
            drive(0,0,0,255,1);
            chk($sformatf("max.c%0d", i), count, i);
            chk($sformatf("max.w%0d", i), wrap, i == 255);
        end
        drive(0,0,0,255,1); chk_all("max.done", 0, 0, 1, 0, 0, 0);

        // asynchronous reset mid-run
        drive(1,0,0,9,3);
        for (int i = 0; i < 5; i++) drive(0,0,0,9,3);
        chk("arst.pre", count, 4);
        #2 reset_n = 1'b0;
        #1 chk_all("arst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(0,0,0,9,3); chk_all("arst.idle", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter_sched.md
Name: mod_counter_sched

Overview:
- Run-time programmable interval scheduler built around a modulo counter.
- On a start pulse it latches a terminal value and a repeat count, then sequences the counter through that many full periods.
- Supports pause and abort, emits one wrap pulse per period and one done pulse at the end.
- Sits between control logic (FSMs, button debouncers, bus registers) and any datapath that needs periodic ticks or a bounded burst of them.

Parameters:
- WIDTH, 8, counter width; the terminal value ranges 0..2^WIDTH-1, inclusive.
- RPT_WIDTH, 4, repeat-count width; a repeat count of 0 means run continuously.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a run; sampled only in IDLE.
- stop  input  1  abort; highest priority.
- pause  input  1  level; holds the count while high.
- period  input  WIDTH  terminal value, inclusive; the counter runs 0..period.
- repeat_cnt  input  RPT_WIDTH  number of periods to run; 0 = continuous.
- count  output  WIDTH  current counter value.
- wrap  output  1  high in the cycle count==period_l and the counter is enabled.
- done  output  1  one-cycle pulse after the final wrap.
- busy  output  1  high in RUN or PAUSE.
- paused  output  1  high in PAUSE.
- periods_left  output  RPT_WIDTH  remaining periods, including the current one; holds 0 in continuous mode.

Behaviour:
- Reset (async, reset_n low): state IDLE; count, period_l, rpt_l, periods_left cleared; wrap, done, busy and paused all low.
- FSM states: IDLE, RUN, PAUSE. Signal priority: stop > pause > counting.
- IDLE:
  - start=1 and stop=0 → latch period_l=period, rpt_l=repeat_cnt, periods_left=repeat_cnt; next state RUN.
  - count stays 0 throughout IDLE.
- Counter enable: en = busy & ~pause & ~stop.
- When en=1:
  - If count==period_l: count←0 and wrap=1.
  - Otherwise: count←count+1.
- wrap is a combinational decode of registered state, gated by en.
- Period bookkeeping on each wrap when rpt_l≠0:
  - periods_left decrements.
  - If periods_left==1: next state IDLE and a registered done pulse in the following cycle.
- Timing for start sampled in cycle N, period P, repeat R, no pause:
  - busy=1 and count=0 in cycle N+1.
  - count=k in cycle N+1+k.
  - The first wrap is in cycle N+1+P.
  - The final wrap is in cycle N+R(P+1).
  - done=1, busy=0, count=0 in cycle N+R(P+1)+1.
- period=0: count stays 0 and wrap is high every enabled cycle.
- Continuous mode (rpt_l=0): wraps forever and never asserts done; only stop ends the run.
- Pause:
  - pause=1 in RUN → no increment or wrap that cycle; next state PAUSE.
  - In PAUSE, count and periods_left hold.
  - pause=0 in PAUSE → counting resumes in that same cycle; next state RUN.
  - paused lags pause by one cycle.
- stop in RUN or PAUSE: next state IDLE; count and periods_left clear; no done pulse. A wrap in the same cycle is suppressed.
- start while busy is ignored. start and stop together in IDLE → stay IDLE.
- start in the done cycle is accepted, since the state is already IDLE.
- period and repeat_cnt changes while busy have no effect, because only the latched copies are used.
- Count arithmetic is WIDTH-bit unsigned. With period=2^WIDTH-1 the counter wraps naturally, but the compare against period_l still drives wrap.
- Async reset mid-run aborts immediately to the reset values above.

Decomposition:
- Shared package mod_sched_pkg holds:
  - the state enum typedef (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - the continuous-mode constant RPT_CONT=0.
- Sub-module mod_counter_prog contains the counter and comparator.
  - Parameter: WIDTH.
  - Ports: clk, reset_n, en, clr, terminal[WIDTH-1:0] → q, wrap.
  - The top level keeps the FSM, the latches and the repeat bookkeeping.

Test Plan:
- period=3, repeat_cnt=2, start pulse at cycle 10 → count runs 0,1,2,3,0,1,2,3 over cycles 11–18; wrap at 14 and 18; done at 19; busy low at 19.
- period=0, repeat_cnt=3 → wrap high for 3 consecutive cycles; done one cycle after the last wrap; count stays 0.
- period=5, repeat_cnt=0, pause high for 4 cycles at count=2 → count holds 2 for 4 cycles then resumes at 3; paused high for 4 cycles starting one cycle late; no done after 50 cycles.
- period=7, repeat_cnt=1, stop at count=4 → count=0 and busy=0 next cycle; done never pulses; start afterwards begins a fresh run from 0.
- period changed from 3 to 9 and start re-pulsed mid-run → no effect; wraps stay every 4 cycles.
- Back-to-back: start asserted in the done cycle → new run, with count=0 and busy=1 the next cycle. Separately, reset_n pulsed low mid-run → all outputs 0 asynchronously.
